msu_data_ctrl: RTL and testbench

Sequencer for the MSU-1 data channel. It owns the seek registers ($2000-$2003 writes), runs the seek and fetch handshakes with the HPS, and keeps a small prefetch FIFO of data bytes. It serves $2001 reads from that FIFO and drives the data-busy status bit. It sits beside the MSU register block: it feeds that block's MSU_READ byte and the data_busy bit, and the HPS side supplies bytes one request at a time.

---
 rtl/msu_data_ctrl.sv | 148 ++++++++++++++
 tb/tb_msu_data_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_data_ctrl.sv
// MSU-1 data channel sequencer: owns the seek registers, runs the HPS seek and
// fetch handshakes, and serves $2001 reads from a small prefetch FIFO.
module msu_data_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [23:0] ADDR,
  input  logic [7:0]  DIN,
  output logic [7:0]  data_dout,
  output logic        data_busy,
  output logic        underrun,
  output logic [31:0] seek_addr,
  output logic        seek_req,
  input  logic        seek_ack,
  output logic [31:0] fetch_addr,
  output logic        fetch_req,
  input  logic        fetch_valid,
  input  logic [7:0]  fetch_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_SEEK, S_FILL, S_READY} state_e;

  state_e        state_q, state_d;
  logic          wr_lvl_q, rd_lvl_q;
  logic [31:0]   seek_base_q, seek_base_d;
  logic [31:0]   seek_addr_q, seek_addr_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          out_q, out_d;
  logic          under_q, under_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic wr_act, rd_act, wr_stb, rd_stb;
  logic seek_wr, seek_start, rd_data;
  logic busy, freq, accept, push, pop, flush;
  logic unused_addr_hi;

  assign unused_addr_hi = ^ADDR[23:16];

  always_comb begin
    wr_act     = ENABLE & ~WR_N;
    rd_act     = ENABLE & ~RD_N;
    wr_stb     = wr_act & ~wr_lvl_q;
    rd_stb     = rd_act & ~rd_lvl_q;
    seek_wr    = wr_stb && (ADDR[15:2] == 14'h0800);
    seek_start = seek_wr && (ADDR[1:0] == 2'd3);
    rd_data    = rd_stb && (ADDR[15:0] == 16'h2001);

    busy   = (state_q == S_DRAIN) || (state_q == S_SEEK) || (state_q == S_FILL);
    // Only one byte may be in flight, so a request needs no outstanding fetch.
    freq   = ((state_q == S_FILL) || (state_q == S_READY)) && !out_q && (count_q < FULL);
    accept = fetch_valid && out_q;
    push   = accept && ((state_q == S_FILL) || (state_q == S_READY));
    pop    = rd_data && !busy && (count_q != '0);

    seek_base_d = seek_base_q;
    if (seek_wr) seek_base_d[{ADDR[1:0], 3'b000} +: 8] = DIN;

    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    state_d = state_q;
    unique case (state_q)
      S_DRAIN: if (!out_q || fetch_valid) state_d = S_SEEK;
      S_SEEK:  if (seek_ack) state_d = S_FILL;
      S_FILL:  if (count_d == FULL) state_d = S_READY;
      default: ;
    endcase
    // A request issued this same cycle is already in flight and must be drained.
    if (seek_start) state_d = (out_q || freq) ? S_DRAIN : S_SEEK;

    flush = (state_d == S_SEEK) && ((state_q != S_SEEK) || seek_start);

    out_d = out_q;
    if (freq) out_d = 1'b1;
    else if (accept) out_d = 1'b0;

    seek_addr_d  = seek_addr_q;
    fetch_addr_d = accept ? fetch_addr_q + 32'd1 : fetch_addr_q;
    if (flush) begin
      seek_addr_d  = seek_base_d;
      fetch_addr_d = seek_base_d;
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end

    under_d = under_q;
    if (rd_data && !busy && (count_q == '0)) under_d = 1'b1;
    if (seek_start) under_d = 1'b0;

    dout_d = pop ? mem_q[rd_ptr_q] : dout_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      wr_lvl_q     <= 1'b0;
      rd_lvl_q     <= 1'b0;
      seek_base_q  <= '0;
      seek_addr_q  <= '0;
      fetch_addr_q <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_q        <= 1'b0;
      under_q      <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_lvl_q     <= wr_act;
      rd_lvl_q     <= rd_act;
      seek_base_q  <= seek_base_d;
      seek_addr_q  <= seek_addr_d;
      fetch_addr_q <= fetch_addr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_q        <= out_d;
      under_q      <= under_d;
      dout_q       <= dout_d;
    end
  end

  // FIFO storage carries data only; validity is tracked by count and pointers.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= fetch_data;
  end

  assign data_dout  = dout_q;
  assign data_busy  = busy;
  assign underrun   = under_q;
  assign seek_addr  = seek_addr_q;
  assign seek_req   = (state_q == S_SEEK);
  assign fetch_addr = fetch_addr_q;
  assign fetch_req  = freq;

endmodule

// File: tb/tb_msu_data_ctrl.sv
// Bench for msu_data_ctrl: queue-based reference model, per-cycle output compare,
// an emulated HPS, directed scenarios and a randomized phase.
module tb_msu_data_ctrl;
  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_DRAIN = 1, M_SEEK = 2, M_FILL = 3, M_READY = 4;

  logic        CLK = 0, RST_N = 0, ENABLE = 0, RD_N = 1, WR_N = 1;
  logic [23:0] ADDR = '0;
  logic [7:0]  DIN = '0;
  logic [7:0]  data_dout;
  logic        data_busy, underrun, seek_req, fetch_req;
  logic [31:0] seek_addr, fetch_addr;
  logic        seek_ack = 0, fetch_valid = 0;
  logic [7:0]  fetch_data = '0;

  msu_data_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .RD_N(RD_N), .WR_N(WR_N),
    .ADDR(ADDR), .DIN(DIN), .data_dout(data_dout), .data_busy(data_busy),
    .underrun(underrun), .seek_addr(seek_addr), .seek_req(seek_req),
    .seek_ack(seek_ack), .fetch_addr(fetch_addr), .fetch_req(fetch_req),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int          m_mode;
  logic [31:0] m_base, m_saddr, m_faddr;
  logic [7:0]  m_q[$];
  bit          m_out, m_under, m_wprev, m_rprev;
  logic [7:0]  m_dout;

  // Emulated HPS
  bit          hps_pend = 0, hps_stall = 0, spurious = 0;
  int          hps_cnt = 0, hps_lat = 2, ack_delay = 5, seek_cnt = 0;
  logic [7:0]  hps_byte = '0;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  function automatic bit m_busy();
    return (m_mode == M_DRAIN) || (m_mode == M_SEEK) || (m_mode == M_FILL);
  endfunction

  function automatic bit m_freq();
    return ((m_mode == M_FILL) || (m_mode == M_READY)) && !m_out && (m_q.size() < DEPTH);
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE; m_base = '0; m_saddr = '0; m_faddr = '0; m_q.delete();
    m_out = 0; m_under = 0; m_wprev = 0; m_rprev = 0; m_dout = '0;
  endtask

  task automatic m_enter_seek();
    m_mode = M_SEEK; m_q.delete(); m_saddr = m_base; m_faddr = m_base;
  endtask

  task automatic model_step();
    bit wstb, rstb, freq, busy, old_out, ss;
    int old_mode;
    if (!RST_N) begin m_reset(); return; end
    wstb = ENABLE && !WR_N && !m_wprev;
    rstb = ENABLE && !RD_N && !m_rprev;
    m_wprev = ENABLE && !WR_N;
    m_rprev = ENABLE && !RD_N;
    freq = m_freq(); busy = m_busy(); old_out = m_out; old_mode = m_mode; ss = 0;
    if (wstb && ADDR[15:2] == 14'h0800) begin
      m_base[ADDR[1:0]*8 +: 8] = DIN;
      ss = (ADDR[1:0] == 2'd3);
    end
    if (rstb && ADDR[15:0] == 16'h2001 && !busy) begin
      if (m_q.size() > 0) m_dout = m_q.pop_front();
      else m_under = 1;
    end
    if (fetch_valid && old_out) begin
      m_out = 0;
      if (old_mode == M_FILL || old_mode == M_READY) m_q.push_back(fetch_data);
      m_faddr = m_faddr + 32'd1;
    end
    if (freq) m_out = 1;
    case (old_mode)
      M_DRAIN: if (!old_out || fetch_valid) m_enter_seek();
      M_SEEK:  if (seek_ack) m_mode = M_FILL;
      M_FILL:  if (m_q.size() == DEPTH) m_mode = M_READY;
      default: ;
    endcase
    if (ss) begin
      m_under = 0;
      if (old_out || freq) m_mode = M_DRAIN;
      else m_enter_seek();
    end
  endtask

  task automatic check_outputs();
    chk("data_dout", data_dout, m_dout);
    chk("data_busy", data_busy, m_busy());
    chk("underrun", underrun, m_under);
    chk("seek_addr", seek_addr, m_saddr);
    chk("seek_req", seek_req, m_mode == M_SEEK);
    chk("fetch_addr", fetch_addr, m_faddr);
    chk("fetch_req", fetch_req, m_freq());
  endtask

  task automatic hps_drive();
    seek_ack = 0; fetch_valid = 0;
    if (m_mode == M_SEEK) begin
      if (seek_cnt >= ack_delay) begin seek_ack = 1; seek_cnt = 0; end
      else seek_cnt++;
    end else begin
      seek_cnt = 0;
      if (spurious && $urandom_range(0, 19) == 0) seek_ack = 1;
    end
    if (hps_pend) begin
      if (!hps_stall) begin
        if (hps_cnt == 0) begin
          fetch_valid = 1; fetch_data = hps_byte; hps_byte++; hps_pend = 0;
        end else hps_cnt--;
      end
    end else if (m_freq()) begin
      hps_pend = 1; hps_cnt = hps_lat - 1;
    end else if (spurious && !m_out && $urandom_range(0, 19) == 0) begin
      fetch_valid = 1; fetch_data = 8'($urandom());
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_outputs();
    hps_drive();
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    ADDR = {8'($urandom_range(0, 255)), a}; DIN = d; ENABLE = 1; WR_N = 0;
    tick();
    WR_N = 1; ENABLE = 0;
    tick();
  endtask

  task automatic cpu_rd(input logic [15:0] a, input int hold);
    ADDR = {8'($urandom_range(0, 255)), a}; ENABLE = 1; RD_N = 0;
    repeat (hold) tick();
    RD_N = 1; ENABLE = 0;
    tick();
  endtask

  task automatic write_seek(input logic [31:0] base);
    for (int i = 0; i < 4; i++) cpu_wr(16'h2000 + 16'(i), base[i*8 +: 8]);
  endtask

  task automatic wait_ready(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!data_busy) done = 1;
    end
    if (!done) chk("wait_ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dout"}, data_dout, 32'h0);
    chk({tag, "_busy"}, data_busy, 32'h0);
    chk({tag, "_underrun"}, underrun, 32'h0);
    chk({tag, "_seek_addr"}, seek_addr, 32'h0);
    chk({tag, "_seek_req"}, seek_req, 32'h0);
    chk({tag, "_fetch_addr"}, fetch_addr, 32'h0);
    chk({tag, "_fetch_req"}, fetch_req, 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_valid;
    int r;
    m_reset();
    repeat (3) tick();
    chk_reset("reset");
    RST_N = 1;
    tick();

    // Seek to 0x00012340, ack after 5 cycles, bytes 0x00..0x07
    hps_byte = 8'h00; ack_delay = 5; hps_lat = 1;
    write_seek(32'h0001_2340);
    chk("seek_req_up", seek_req, 32'h1);
    chk("seek_busy_up", data_busy, 32'h1);
    chk("seek_addr_lit", seek_addr, 32'h0001_2340);
    wait_ready(200);
    chk("fill_fetch_addr", fetch_addr, 32'h0001_2348);
    chk("fill_busy", data_busy, 32'h0);

    // Eight reads with HPS stalled, then a ninth underruns
    hps_stall = 1;
    for (int i = 0; i < 8; i++) begin
      cpu_rd(16'h2001, 3);
      chk("rd_byte", data_dout, 32'(i));
      if (i == 0) begin
        chk("refill_req", fetch_req, 32'h0) ; // request was taken the cycle after assertion
        chk("refill_addr", fetch_addr, 32'h0001_2348);
      end
    end
    cpu_rd(16'h2001, 2);
    chk("underrun_set", underrun, 32'h1);
    chk("underrun_dout", data_dout, 32'h07);
    hps_stall = 0;
    cpu_wr(16'h2003, 8'h00);
    chk("underrun_clr", underrun, 32'h0);
    wait_ready(300);

    // Seek with a fetch outstanding goes through DRAIN
    hps_lat = 8;
    cpu_rd(16'h2001, 1);
    cpu_wr(16'h2003, 8'h00);
    chk("drain_mode", m_mode, M_DRAIN);
    chk("drain_busy", data_busy, 32'h1);
    chk("drain_no_seek", seek_req, 32'h0);
    got_valid = 0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      tick();
      if (fetch_valid) got_valid = 1;
    end
    chk("drain_valid_seen", got_valid, 32'h1);
    hps_byte = 8'hA0;
    tick();
    chk("drain_seek_req", seek_req, 32'h1);
    wait_ready(400);
    cpu_rd(16'h2001, 1);
    chk("post_seek_byte", data_dout, 32'hA0);

    // Address wrap past 2^32
    hps_lat = 1;
    write_seek(32'hFFFF_FFFE);
    wait_ready(200);
    chk("wrap_fetch_addr", fetch_addr, 32'h0000_0006);
    chk("wrap_seek_addr", seek_addr, 32'hFFFF_FFFE);

    // Asynchronous reset during FILL, then a stray fetch_valid
    hps_lat = 3;
    write_seek(32'h00AB_CD00);
    repeat (ack_delay + 6) tick();
    chk("fill_busy_before_rst", data_busy, 32'h1);
    #2 RST_N = 0;
    #1 chk_reset("async_rst");
    m_reset(); hps_pend = 0; seek_cnt = 0;
    repeat (2) tick();
    RST_N = 1;
    fetch_valid = 1; fetch_data = 8'h55;
    tick();
    seek_ack = 1;
    tick();
    cpu_rd(16'h2001, 1);
    chk("stray_underrun", underrun, 32'h1);
    chk("stray_dout", data_dout, 32'h0);
    chk("stray_busy", data_busy, 32'h0);

    // Randomized phase
    spurious = 1;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 29) == 0) hps_stall = !hps_stall;
      hps_lat = $urandom_range(1, 4);
      ack_delay = $urandom_range(0, 6);
      if (r < 6) write_seek($urandom());
      else if (r < 10) cpu_wr(16'h2003, 8'($urandom()));
      else if (r < 50) cpu_rd(16'h2001, $urandom_range(1, 3));
      else if (r < 55) cpu_rd(16'h2000 + 16'($urandom_range(2, 7)), 1);
      else if (r < 58) begin
        ADDR = 24'h002001; ENABLE = 0; RD_N = 0;
        tick();
        RD_N = 1;
        tick();
      end
      else if (r < 62) cpu_wr(16'h2004 + 16'($urandom_range(0, 3)), 8'($urandom()));
      else repeat ($urandom_range(1, 4)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
